comparator_sweep_checker: RTL and testbench
===========================================

Name: comparator_sweep_checker

Overview:
- Drives the operand side of a COMPARATOR instance and reads back its relation flags.
- Sweeps every (A,B) operand pair once per run and checks each flag triple against a golden relation.
- Reports pass/fail, the error count and the first failing pair.
- Replaces free-running counter stimulus with a self-checking, clocked sequencer usable in-system or in benches.

Parameters:
- WIDTH, 4, operand width in bits; matches the A0_A3/B0_B3 buses.
- SETTLE, 2, cycles operands are held before the flags are sampled; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that launches a sweep; ignored while busy.
- A0_A3  out  WIDTH  operand A to the comparator.
- B0_B3  out  WIDTH  operand B to the comparator.
- cmp_enable  out  1  comparator enable; high only while busy.
- A  in  1  comparator flag: operand A > operand B.
- B  in  1  comparator flag: operand A == operand B.
- C  in  1  comparator flag: operand A < operand B.
- busy  out  1  sweep in progress.
- done  out  1  level, high from sweep completion until the next start.
- pass  out  1  valid while done; 1 when err_count == 0.
- err_count  out  2*WIDTH+1  number of failing vectors in the last sweep.
- first_err_a  out  WIDTH  operand A of the first failing vector.
- first_err_b  out  WIDTH  operand B of the first failing vector.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including A0_A3, B0_B3, cmp_enable, busy, done, pass, err_count, first_err_a and first_err_b.
  - Reset mid-sweep aborts the sweep immediately; no partial result is retained.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE → DRIVE on start:
  - Operands set to 0/0.
  - err_count and first_err cleared; internal first-error flag cleared.
  - busy and cmp_enable go to 1 in the cycle after start.
- DRIVE: operands held stable for exactly SETTLE cycles (settle counter), then → SAMPLE.
- SAMPLE, one cycle:
  - Golden one-hot value: {gt,eq,lt} = {A0_A3>B0_B3, A0_A3==B0_B3, A0_A3<B0_B3}.
  - The vector fails if {A,B,C} differs from golden. This includes all-zero and multi-hot flag triples.
  - On fail, err_count increments. If this is the first failure of the sweep, first_err_a/b capture the current operands.
- Operand ordering:
  - A0_A3 is the inner index. B0_B3 increments when A0_A3 wraps from 2^WIDTH-1 to 0.
  - After sampling A = B = 2^WIDTH-1 → DONE.
  - Otherwise advance the operands → DRIVE.
- Per-vector cost is SETTLE+1 cycles. A sweep takes 2^(2*WIDTH)*(SETTLE+1) cycles from the first DRIVE cycle; defaults give 768.
- err_count width holds the maximum of 2^(2*WIDTH) failures, so no saturation logic is needed.
- DONE:
  - busy = 0, cmp_enable = 0, done = 1.
  - pass = (err_count == 0).
  - Operands hold their last value.
- DONE → DRIVE on start (restart): counters cleared exactly as from IDLE; done drops in the same cycle busy rises.
- start while busy (DRIVE/SAMPLE) has no effect.
- Flags are sampled only in SAMPLE; flag activity in other states is ignored.

Decomposition:
- Shared package cmp_pkg holds:
  - state enum (IDLE, DRIVE, SAMPLE, DONE);
  - flag index constants GT_IDX = 2, EQ_IDX = 1, LT_IDX = 0;
  - default operand width CMP_WIDTH = 4.
- Sub-module op_pair_counter:
  - clear and advance inputs; outputs the A/B operand pair and a last flag.
  - Two chained WIDTH-bit counters with carry from A into B.
- FSM, checker and result registers live in the top module.

Test Plan:
- Correct behavioural comparator, defaults, start at cycle 10 → busy for 768 cycles, then done = 1, pass = 1, err_count = 0; cmp_enable = 0 after done.
- Comparator with the eq flag stuck at 1 → err_count = 240, first_err_a = 1, first_err_b = 0, pass = 0.
- Comparator with gt/lt swapped → err_count = 240, first_err = (1,0); equal pairs all pass.
- Single fault forced at A = 5, B = 9 (flags 000) → err_count = 1, first_err_a = 5, first_err_b = 9.
- Reset low at cycle 300 for 2 cycles, then start → all outputs 0 during reset, and a full clean 768-cycle sweep follows with pass = 1.
- start pulses at cycles 50 and 400 during a sweep → ignored, completion timing unchanged. start after done → restart, err_count re-cleared, done falls as busy rises.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator sweep checker.
package cmp_pkg;

  localparam int unsigned CMP_WIDTH = 4;

  // Bit positions of the relation flags within a {gt,eq,lt} triple
  localparam int unsigned GT_IDX = 2;
  localparam int unsigned EQ_IDX = 1;
  localparam int unsigned LT_IDX = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } cmp_state_e;

endpackage

// File: rtl/op_pair_counter.sv
// Operand pair generator: A is the inner index, and it carries into B when it wraps.
module op_pair_counter
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             last_c
);

  localparam logic [WIDTH-1:0] OP_MAX = {WIDTH{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
    end else if (clear) begin
      a <= '0;
      b <= '0;
    end else if (advance) begin
      a <= a + WIDTH'(1);
      if (a == OP_MAX) begin
        b <= b + WIDTH'(1);
      end
    end
  end

  assign last_c = (a == OP_MAX) && (b == OP_MAX);

endmodule

// File: rtl/comparator_sweep_checker.sv
// Sweeps every (A,B) operand pair through an external comparator and checks each
// returned {gt,eq,lt} flag triple against the golden relation.
module comparator_sweep_checker
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = CMP_WIDTH,
  parameter int unsigned SETTLE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   A0_A3,
  output logic [WIDTH-1:0]   B0_B3,
  output logic               cmp_enable,
  input  logic               A,
  input  logic               B,
  input  logic               C,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  cmp_state_e       state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [ERR_W-1:0] err_d;
  logic [WIDTH-1:0] first_a_d, first_b_d;
  logic             seen_q, seen_d;
  logic             clear_c, advance_c, last_c;
  logic [2:0]       golden_c, observed_c;

  op_pair_counter #(
    .WIDTH (WIDTH)
  ) u_pair (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (clear_c),
    .advance (advance_c),
    .a       (A0_A3),
    .b       (B0_B3),
    .last_c  (last_c)
  );

  // Golden relation for the operands currently on the bus, and the flags as returned
  always_comb begin
    golden_c           = '0;
    observed_c         = '0;
    golden_c[GT_IDX]   = (A0_A3 >  B0_B3);
    golden_c[EQ_IDX]   = (A0_A3 == B0_B3);
    golden_c[LT_IDX]   = (A0_A3 <  B0_B3);
    observed_c[GT_IDX] = A;
    observed_c[EQ_IDX] = B;
    observed_c[LT_IDX] = C;
  end

  // Next-state, settle timing and result bookkeeping
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    err_d     = err_count;
    first_a_d = first_err_a;
    first_b_d = first_err_b;
    seen_d    = seen_q;
    clear_c   = 1'b0;
    advance_c = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = DRIVE;
          settle_d  = '0;
          err_d     = '0;
          first_a_d = '0;
          first_b_d = '0;
          seen_d    = 1'b0;
          clear_c   = 1'b1;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (observed_c != golden_c) begin
          err_d = err_count + ERR_W'(1);
          if (!seen_q) begin
            seen_d    = 1'b1;
            first_a_d = A0_A3;
            first_b_d = B0_B3;
          end
        end
        if (last_c) begin
          state_d = DONE;
        end else begin
          advance_c = 1'b1;
          state_d   = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; status flags follow the next state so they align with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      seen_q      <= 1'b0;
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
      busy        <= 1'b0;
      cmp_enable  <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      seen_q      <= seen_d;
      err_count   <= err_d;
      first_err_a <= first_a_d;
      first_err_b <= first_b_d;
      busy        <= (state_d == DRIVE) || (state_d == SAMPLE);
      cmp_enable  <= (state_d == DRIVE) || (state_d == SAMPLE);
      done        <= (state_d == DONE);
      pass        <= (state_d == DONE) && (err_d == '0);
    end
  end

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Randomized scoreboard bench for comparator_sweep_checker with a behavioural comparator.
module tb_comparator_sweep_checker;

  localparam int unsigned W         = 4;
  localparam int unsigned SETTLE    = 2;
  localparam int unsigned NPAIR     = 256;
  localparam int unsigned SWEEP_CYC = NPAIR * (SETTLE + 1);

  typedef struct packed {
    logic [8:0] err;
    logic [3:0] fa;
    logic [3:0] fb;
    logic       pass;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_op, b_op;
  logic         cmp_enable, busy, done, pass;
  logic         flag_gt, flag_eq, flag_lt;
  logic [2*W:0] err_count;
  logic [W-1:0] first_err_a, first_err_b;

  // 0 correct, 1 eq stuck-at-1, 2 gt/lt swapped, 3 flags 000 at (5,9), 4 random fault map
  int           mode = 0;
  bit           fault_en [NPAIR];
  logic [2:0]   fault_val [NPAIR];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   results_seen = 0;
  int   sweeps_issued = 0;

  always #5 clk = ~clk;

  comparator_sweep_checker #(
    .WIDTH  (W),
    .SETTLE (SETTLE)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .A0_A3       (a_op),
    .B0_B3       (b_op),
    .cmp_enable  (cmp_enable),
    .A           (flag_gt),
    .B           (flag_eq),
    .C           (flag_lt),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .first_err_a (first_err_a),
    .first_err_b (first_err_b)
  );

  function automatic logic [2:0] golden(input int a, input int b);
    return {(a > b), (a == b), (a < b)};
  endfunction

  function automatic logic [2:0] model_flags(input int a, input int b);
    logic [2:0] g;
    g = golden(a, b);
    case (mode)
      1: return g | 3'b010;
      2: return {g[0], g[1], g[2]};
      3: return (a == 5 && b == 9) ? 3'b000 : g;
      4: return fault_en[b * 16 + a] ? fault_val[b * 16 + a] : g;
      default: return g;
    endcase
  endfunction

  always_comb {flag_gt, flag_eq, flag_lt} = model_flags(int'(a_op), int'(b_op));

  // Expected sweep result: enumerate pairs in sweep order and count disagreeing triples
  function automatic exp_t reference();
    exp_t r;
    bit   found;
    r     = '0;
    found = 1'b0;
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 16; a++) begin
        if (model_flags(a, b) != golden(a, b)) begin
          r.err = r.err + 9'd1;
          if (!found) begin
            found = 1'b1;
            r.fa  = 4'(a);
            r.fb  = 4'(b);
          end
        end
      end
    end
    r.pass = (r.err == 9'd0);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_op"}, 32'(a_op), 0);
    check({tag, "_b_op"}, 32'(b_op), 0);
    check({tag, "_cmp_enable"}, 32'(cmp_enable), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
    check({tag, "_first_err_a"}, 32'(first_err_a), 0);
    check({tag, "_first_err_b"}, 32'(first_err_b), 0);
  endtask

  // Monitor: on each rising edge of done, pop the expected result and compare
  int   busy_cycles = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cycles = 0;
      done_prev   = 1'b0;
    end else begin
      if (busy) busy_cycles++;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending sweep (t=%0t)", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("err_count", 32'(err_count), 32'(e.err));
          check("first_err_a", 32'(first_err_a), 32'(e.fa));
          check("first_err_b", 32'(first_err_b), 32'(e.fb));
          check("pass", 32'(pass), 32'(e.pass));
          check("busy_cycles", 32'(busy_cycles), SWEEP_CYC);
          check("cmp_enable_after_done", 32'(cmp_enable), 0);
          check("busy_after_done", 32'(busy), 0);
          results_seen++;
        end
        busy_cycles = 0;
      end
      done_prev = done;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_sweep(input bit stray_starts);
    int n;
    bit was_done;
    was_done = done;
    pulse_start();
    exp_q.push_back(reference());
    sweeps_issued++;
    @(negedge clk);
    check("busy_rises", 32'(busy), 1);
    check("cmp_enable_rises", 32'(cmp_enable), 1);
    check("done_falls", 32'(done), 0);
    check("err_cleared", 32'(err_count), 0);
    if (was_done) check("restart_pass_cleared", 32'(pass), 0);
    n = 1;
    while (!done && n < int'(SWEEP_CYC) + 50) begin
      start = stray_starts && (n == 50 || n == 400);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout: got done=0 expected done=1 after %0d cycles", n);
    end
    @(negedge clk);
    repeat ($urandom_range(1, 20)) @(negedge clk);
  endtask

  task automatic randomize_faults();
    int nf, idx;
    logic [2:0] v;
    for (int i = 0; i < int'(NPAIR); i++) fault_en[i] = 1'b0;
    nf = $urandom_range(0, 6);
    for (int k = 0; k < nf; k++) begin
      idx = $urandom_range(0, NPAIR - 1);
      do v = 3'($urandom_range(0, 7)); while (v == golden(idx % 16, idx / 16));
      fault_en[idx]  = 1'b1;
      fault_val[idx] = v;
    end
  endtask

  initial begin
    for (int i = 0; i < int'(NPAIR); i++) begin
      fault_en[i]  = 1'b0;
      fault_val[i] = 3'b000;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    mode = 0;
    run_sweep(1'b1);
    mode = 1;
    run_sweep(1'b0);
    mode = 2;
    run_sweep(1'b0);
    mode = 3;
    run_sweep(1'b1);
    mode = 4;
    for (int r = 0; r < 4; r++) begin
      randomize_faults();
      run_sweep(r[0]);
    end

    // Abort a sweep with reset; nothing from it may survive
    mode = 1;
    pulse_start();
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    @(negedge clk);
    check_all_zero("midreset_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    mode = 0;
    run_sweep(1'b0);

    check("results_seen", 32'(results_seen), 32'(sweeps_issued));
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
